// File: rtl/audio_pkg.sv
// audio_pkg: shared word width, capture FSM states and bit-counter sizing
package audio_pkg;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_w(DEF_DATA_W);
endpackage

// File: rtl/i2s_pair_buffer.sv
// i2s_pair_buffer: valid/ready holding register for a stereo pair with mono mix and sticky overrun
module i2s_pair_buffer
  import audio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_ready,
  input  logic              i_clr_ovr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic [DATA_W-1:0] o_mono,
  output logic              o_overrun
);
  logic              w_take;
  logic [DATA_W:0]   w_sum;
  assign w_take = i_load && (!o_valid || i_ready);
  // one extra bit keeps the sum exact, so halving it can never wrap
  assign w_sum  = {i_left[DATA_W-1], i_left} + {i_right[DATA_W-1], i_right};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_left    <= '0;
      o_right   <= '0;
      o_mono    <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_valid   <= w_take || (o_valid && !i_ready);
      o_left    <= w_take ? i_left : o_left;
      o_right   <= w_take ? i_right : o_right;
      o_mono    <= w_take ? w_sum[DATA_W:1] : o_mono;
      o_overrun <= (i_load && o_valid && !i_ready) || (o_overrun && !i_clr_ovr);
    end
endmodule

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: I2S ADC deserializer pairing left/right words into a valid/ready stream
module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_lrc,
  input  logic              i_adcdat,
  input  logic              i_ready,
  input  logic              i_clr_ovr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic [DATA_W-1:0] o_mono,
  output logic              o_overrun,
  output logic              o_sync_err
);
  localparam int CW = cnt_w(DATA_W);
  state_t            r_state, w_next;
  logic              r_lrc_q, r_left_ok, r_pair;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-2:0] r_sh;
  logic [DATA_W-1:0] r_left, r_right, w_word;
  logic              w_edge, w_fall, w_shift, w_done, w_err;
  assign w_edge  = i_lrc ^ r_lrc_q;
  assign w_fall  = r_lrc_q & ~i_lrc;
  assign w_shift = r_state == SHIFT && i_en && !w_edge;
  assign w_done  = w_shift && r_cnt == CW'(DATA_W - 1);
  assign w_err   = r_state == SHIFT && i_en && w_edge;
  assign w_word  = {r_sh, i_adcdat};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = SYNC;
      SYNC:    w_next = w_fall ? SHIFT : SYNC;
      SHIFT:   w_next = w_done ? GAP : SHIFT;
      GAP:     w_next = w_edge ? SHIFT : GAP;
      default: w_next = IDLE;
    endcase
    if (!i_en) w_next = IDLE;
  end
  // an LRC edge mid-word restarts the count, so the edge cycle doubles as the new delay bit
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_lrc_q    <= 1'b0;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_left_ok  <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_pair     <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      r_lrc_q    <= i_lrc;
      r_cnt      <= (w_shift && !w_done) ? r_cnt + 1'b1 : '0;
      r_sh       <= w_shift ? w_word[DATA_W-2:0] : r_sh;
      r_left_ok  <= (!i_en || w_err) ? 1'b0 : (w_done ? !r_lrc_q : r_left_ok);
      r_left     <= (w_done && !r_lrc_q) ? w_word : r_left;
      r_right    <= (w_done && r_lrc_q) ? w_word : r_right;
      r_pair     <= w_done && r_lrc_q && r_left_ok;
      o_sync_err <= w_err;
    end
  i2s_pair_buffer #(.DATA_W(DATA_W)) u_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (r_pair),
    .i_left    (r_left),
    .i_right   (r_right),
    .i_ready   (i_ready),
    .i_clr_ovr (i_clr_ovr),
    .o_valid   (o_valid),
    .o_left    (o_left),
    .o_right   (o_right),
    .o_mono    (o_mono),
    .o_overrun (o_overrun)
  );
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver: directed and random I2S frames checked against a pair-queue model
module tb_i2s_adc_receiver;
  localparam int DATA_W = 16;
  typedef struct packed {logic [DATA_W-1:0] l, r;} pair_t;
  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_en = 1'b0;
  logic              i_lrc = 1'b0;
  logic              i_adcdat = 1'b0;
  logic              i_ready = 1'b1;
  logic              i_clr_ovr = 1'b0;
  logic              o_valid, o_overrun, o_sync_err;
  logic [DATA_W-1:0] o_left, o_right, o_mono;
  int                total = 0;
  int                passes = 0;
  int                n_err = 0;
  logic              exp_ovr = 1'b0;
  pair_t             q[$];
  logic [DATA_W-1:0] e_l;
  i2s_adc_receiver #(.DATA_W(DATA_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_lrc      (i_lrc),
    .i_adcdat   (i_adcdat),
    .i_ready    (i_ready),
    .i_clr_ovr  (i_clr_ovr),
    .o_valid    (o_valid),
    .o_left     (o_left),
    .o_right    (o_right),
    .o_mono     (o_mono),
    .o_overrun  (o_overrun),
    .o_sync_err (o_sync_err)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [DATA_W-1:0] mono(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return DATA_W'(s >>> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick();
    pair_t p;
    if (o_valid && i_ready) begin
      if (q.size() == 0) chk("spurious_valid", 32'(o_valid), 0);
      else begin
        p = q.pop_front();
        chk("left", 32'(o_left), 32'(p.l));
        chk("right", 32'(o_right), 32'(p.r));
        chk("mono", 32'(o_mono), 32'(mono(p.l, p.r)));
      end
    end
    @(posedge i_clk);
    #1;
    if (o_sync_err) n_err++;
  endtask
  task automatic reset_mid_word();
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_left", 32'(o_left), 0);
    chk("rst_right", 32'(o_right), 0);
    chk("rst_mono", 32'(o_mono), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    q.delete();
    exp_ovr = 1'b0;
    i_ready = 1'b1;
  endtask
  // cycle 0 of a slot is the I2S delay bit; cut ends the slot early to force an LRC edge mid-word
  task automatic send_slot(input logic lrc, input logic [DATA_W-1:0] w, input int cut = -1,
                           input int en_at = -1, input int rst_at = -1);
    int n;
    n = (cut >= 0) ? cut : DATA_W + 1 + int'($urandom_range(1, 3));
    for (int k = 0; k < n; k++) begin
      i_rst_n  = 1'b1;
      i_lrc    = lrc;
      i_adcdat = (k >= 1 && k <= DATA_W) ? w[DATA_W-k] : 1'($urandom);
      if (k == en_at) i_en = 1'b1;
      if (k == rst_at) reset_mid_word();
      tick();
    end
  endtask
  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    send_slot(1'b0, l);
    if (!i_ready && q.size() > 0) exp_ovr = 1'b1;
    else q.push_back('{l, r});
    send_slot(1'b1, r);
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_left", 32'(o_left), 0);
    chk("reset_right", 32'(o_right), 0);
    chk("reset_mono", 32'(o_mono), 0);
    chk("reset_overrun", 32'(o_overrun), 0);
    chk("reset_sync_err", 32'(o_sync_err), 0);
    i_rst_n = 1'b1;
    tick();
    send_slot(1'b0, DATA_W'($urandom));
    send_slot(1'b1, DATA_W'($urandom), -1, 8);
    send_frame(16'h1234, 16'h8765);
    send_frame(16'h8001, 16'h7FFE);
    send_frame(16'h7FFF, 16'h7FFF);
    send_frame(16'h8000, 16'h8000);
    for (int i = 0; i < 6; i++) send_frame(DATA_W'($urandom), DATA_W'($urandom));
    send_slot(1'b0, DATA_W'($urandom), 10);
    send_slot(1'b1, DATA_W'($urandom));
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    chk("sync_err_pulses", 32'(n_err), 1);
    i_ready = 1'b0;
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    e_l = q[0].l;
    chk("held_valid", 32'(o_valid), 1);
    chk("ovr_after_first", 32'(o_overrun), 32'(exp_ovr));
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    chk("ovr_after_second", 32'(o_overrun), 32'(exp_ovr));
    chk("held_left", 32'(o_left), 32'(e_l));
    i_clr_ovr = 1'b1;
    tick();
    i_clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_cleared", 32'(o_overrun), 32'(exp_ovr));
    i_ready = 1'b1;
    tick();
    chk("accept_drops_valid", 32'(o_valid), 0);
    i_ready = 1'b0;
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    chk("pre_rst_valid", 32'(o_valid), 1);
    chk("pre_rst_overrun", 32'(o_overrun), 32'(exp_ovr));
    send_slot(1'b0, DATA_W'($urandom));
    send_slot(1'b1, DATA_W'($urandom), -1, -1, 5);
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    send_frame(DATA_W'($urandom), DATA_W'($urandom));
    repeat (4) tick();
    chk("queue_drained", 32'(q.size()), 0);
    chk("sync_err_total", 32'(n_err), 1);
    chk("final_overrun", 32'(o_overrun), 32'(exp_ovr));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
